// File: rtl/counter_pkg.sv
// Shared definitions for the scaler front end (signal_shaper and friends).
//   shaper_state_t  : per-channel shaper state (IDLE, PULSE, DEAD)
//   N_CHN_DEF       : default channel count
//   SYNC_STAGES_DEF : default synchroniser depth
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2
  } shaper_state_t;

  localparam int N_CHN_DEF       = 32;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/signal_shaper_if.sv
// Bus between the discriminator front end and the signal_shaper.
// Optional feature macro: SIGNAL_SHAPER_PILEUP_EN (adds pileup_clr / pileup).
//   signal_in  [N_CHN]  raw asynchronous discriminator inputs
//   chn_enable [N_CHN]  per-channel accept mask
//   pulse_len  [LEN_W]  output pulse width in clk cycles (0 acts as 1)
//   dead_time  [DEAD_W] low cycles after each pulse before re-arm
//   signal_out [N_CHN]  shaped pulses towards counter.signal
//   busy       [N_CHN]  channel in PULSE or DEAD
//   pileup_clr          clears the sticky pileup flags (optional)
//   pileup     [N_CHN]  sticky "edge arrived while busy" flags (optional)
// master = the side that drives inputs, slave = the shaper itself.
interface signal_shaper_if
  import counter_pkg::*;
#(
  parameter int N_CHN  = N_CHN_DEF,
  parameter int LEN_W  = 4,
  parameter int DEAD_W = 8
);

  logic [N_CHN-1:0]  signal_in;
  logic [N_CHN-1:0]  chn_enable;
  logic [LEN_W-1:0]  pulse_len;
  logic [DEAD_W-1:0] dead_time;
  logic [N_CHN-1:0]  signal_out;
  logic [N_CHN-1:0]  busy;
`ifdef SIGNAL_SHAPER_PILEUP_EN
  logic              pileup_clr;
  logic [N_CHN-1:0]  pileup;

  modport master (
    output signal_in, chn_enable, pulse_len, dead_time, pileup_clr,
    input  signal_out, busy, pileup
  );

  modport slave (
    input  signal_in, chn_enable, pulse_len, dead_time, pileup_clr,
    output signal_out, busy, pileup
  );
`else
  modport master (
    output signal_in, chn_enable, pulse_len, dead_time,
    input  signal_out, busy
  );

  modport slave (
    input  signal_in, chn_enable, pulse_len, dead_time,
    output signal_out, busy
  );
`endif

endinterface

// File: rtl/signal_shaper_chn.sv
// One shaper channel: synchroniser, arm bit, PULSE/DEAD state machine with
// latched pulse length and dead time, optional sticky pileup flag.
// Optional feature macro: SIGNAL_SHAPER_PILEUP_EN.
//   clk, reset_n   clock and asynchronous active-low reset
//   signal_in      raw asynchronous input
//   chn_enable     edges accepted while 1 (looked at only when re-armable)
//   pulse_len      requested pulse width, 0 acts as 1
//   dead_time      low cycles after the pulse
//   pileup_clr     synchronous clear of the pileup flag (optional)
//   signal_out     registered shaped pulse
//   busy           registered "state is not IDLE"
//   pileup         sticky pileup flag (optional)
module signal_shaper_chn
  import counter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int LEN_W       = 4,
  parameter int DEAD_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              signal_in,
  input  logic              chn_enable,
  input  logic [LEN_W-1:0]  pulse_len,
  input  logic [DEAD_W-1:0] dead_time,
`ifdef SIGNAL_SHAPER_PILEUP_EN
  input  logic              pileup_clr,
  output logic              pileup,
`endif
  output logic              signal_out,
  output logic              busy
);

  localparam int CNT_W = (LEN_W > DEAD_W) ? LEN_W : DEAD_W;
  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_PULSE = 2'(PULSE);
  localparam logic [1:0] S_DEAD  = 2'(DEAD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   p_q;
  logic                   arm_q;
  logic [1:0]             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DEAD_W-1:0]      dt_q;

  logic             s;
  logic             rise;
  logic             finishing;
  logic             accept;
  logic [LEN_W-1:0] len_eff;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~p_q & arm_q;
  assign len_eff = (pulse_len == '0) ? LEN_W'(1) : pulse_len;

  // The final cycle of the dead time (or of the pulse when dead_time is 0)
  // doubles as the re-arm cycle, so accepted edges can be exactly len+dt
  // cycles apart rather than len+dt+1.
  assign finishing = (cnt_q == '0) &&
                     ((state_q == S_DEAD) || (state_q == S_PULSE && dt_q == '0));
  assign accept    = rise & chn_enable & ((state_q == S_IDLE) | finishing);

  // Synchroniser plus edge history. fill_q marks when the synchroniser holds
  // real samples instead of reset zeros, so an input held high through reset
  // release cannot masquerade as a low level and arm the channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      fill_q <= '0;
      p_q    <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      p_q    <= s;
      arm_q  <= arm_q | (fill_q[SYNC_STAGES-1] & ~s);
    end
  end

  // Pulse / dead-time sequencer; len and dt are captured on acceptance so
  // config changes only affect the next accepted edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dt_q    <= '0;
    end else if (accept) begin
      state_q <= S_PULSE;
      cnt_q   <= CNT_W'(len_eff) - CNT_W'(1);
      dt_q    <= dead_time;
    end else begin
      case (state_q)
        S_PULSE: begin
          if (cnt_q == '0) begin
            if (dt_q == '0) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DEAD;
              cnt_q   <= CNT_W'(dt_q) - CNT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DEAD: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs registered from the state so the counters see glitch-free levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      signal_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      signal_out <= (state_q == S_PULSE);
      busy       <= (state_q != S_IDLE);
    end
  end

`ifdef SIGNAL_SHAPER_PILEUP_EN
  // Sticky flag for edges thrown away while busy; a new set beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pileup <= 1'b0;
    end else if (rise && (state_q != S_IDLE) && !accept) begin
      pileup <= 1'b1;
    end else if (pileup_clr) begin
      pileup <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/signal_shaper.sv
// Front-end conditioner for the 32-channel scaler: one signal_shaper_chn per
// channel, no shared state between channels.
// Optional feature macro: SIGNAL_SHAPER_PILEUP_EN (pileup_clr / pileup on bus).
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      signal_shaper_if slave modport (inputs, config, shaped outputs)
module signal_shaper
  import counter_pkg::*;
#(
  parameter int N_CHN       = N_CHN_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int LEN_W       = 4,
  parameter int DEAD_W      = 8
) (
  input logic            clk,
  input logic            reset_n,
  signal_shaper_if.slave bus
);

  wire [N_CHN-1:0] out_w;
  wire [N_CHN-1:0] busy_w;
`ifdef SIGNAL_SHAPER_PILEUP_EN
  wire [N_CHN-1:0] pile_w;
`endif

  for (genvar i = 0; i < N_CHN; i++) begin : g_chn
    signal_shaper_chn #(
      .SYNC_STAGES (SYNC_STAGES),
      .LEN_W       (LEN_W),
      .DEAD_W      (DEAD_W)
    ) u_chn (
      .clk        (clk),
      .reset_n    (reset_n),
      .signal_in  (bus.signal_in[i]),
      .chn_enable (bus.chn_enable[i]),
      .pulse_len  (bus.pulse_len),
      .dead_time  (bus.dead_time),
`ifdef SIGNAL_SHAPER_PILEUP_EN
      .pileup_clr (bus.pileup_clr),
      .pileup     (pile_w[i]),
`endif
      .signal_out (out_w[i]),
      .busy       (busy_w[i])
    );
  end

  assign bus.signal_out = out_w;
  assign bus.busy       = busy_w;
`ifdef SIGNAL_SHAPER_PILEUP_EN
  assign bus.pileup     = pile_w;
`endif

endmodule
